// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: arbitrates two resolution requesters into
// a 2-bit saturating counter table and the BTB write ports, with a full-table flush walk.
module bp_update_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  output logic             ex_ready,
  input  logic             jr_valid,
  input  logic             jr_taken,
  input  logic [31:0]      jr_pc,
  input  logic [31:0]      jr_target,
  output logic             jr_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic             btb_vbit,
  output logic             btb_tgt_we,
  output logic [31:0]      btb_target
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic             rr_p0;
  logic [1:0]       cnt_p0 [DEPTH];

  logic             we_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             vbit_p1;
  logic             tgt_we_p1;
  logic [31:0]      target_p1;

  logic             blocked;
  logic             ex_gnt;
  logic             jr_gnt;
  logic             xfer;
  logic [31:0]      sel_pc;
  logic             sel_taken;
  logic [31:0]      sel_target;
  logic [IDX_W-1:0] xfer_idx;
  logic [1:0]       cur_cnt;
  logic [1:0]       new_cnt;
  logic             flush_start;
  logic             flush_last;
  logic [IDX_W-1:0] flush_nxt_idx;
  logic             unused_pc_bits;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Stage p0: arbitration and counter lookup (combinational on held request)
  assign blocked = (state_p0 != IDLE) || flush_req;
  assign ex_gnt  = !blocked && ex_valid && (!jr_valid || !rr_p0);
  assign jr_gnt  = !blocked && jr_valid && (!ex_valid || rr_p0);
  assign xfer    = ex_gnt || jr_gnt;

  assign ex_ready = ex_gnt;
  assign jr_ready = jr_gnt;

  always_comb begin
    sel_pc     = ex_pc;
    sel_taken  = ex_taken;
    sel_target = ex_target;
    if (jr_gnt) begin
      sel_pc     = jr_pc;
      sel_taken  = jr_taken;
      sel_target = jr_target;
    end
  end

  assign xfer_idx       = sel_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{sel_pc[31:IDX_W+2], sel_pc[1:0]};
  assign cur_cnt        = cnt_p0[xfer_idx];
  assign new_cnt        = sel_taken ? sat_inc(cur_cnt) : sat_dec(cur_cnt);

  assign flush_start   = (state_p0 == IDLE) && flush_req;
  assign flush_last    = (state_p0 == FLUSH) && (idx_p1 == {IDX_W{1'b1}});
  assign flush_nxt_idx = idx_p1 + IDX_W'(1);

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      rr_p0    <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (ex_gnt)
        rr_p0 <= 1'b1;
      else if (jr_gnt)
        rr_p0 <= 1'b0;
    end
  end

  // Stage p1: registered BTB writes and counter table update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_p0[i] <= 2'd0;
      we_p1     <= 1'b0;
      idx_p1    <= '0;
      vbit_p1   <= 1'b0;
      tgt_we_p1 <= 1'b0;
      target_p1 <= 32'd0;
    end else begin
      we_p1     <= 1'b0;
      tgt_we_p1 <= 1'b0;
      if (flush_start) begin
        we_p1     <= 1'b1;
        idx_p1    <= '0;
        vbit_p1   <= 1'b0;
        cnt_p0[0] <= 2'd0;
      end else if ((state_p0 == FLUSH) && !flush_last) begin
        we_p1                 <= 1'b1;
        idx_p1                <= flush_nxt_idx;
        vbit_p1               <= 1'b0;
        cnt_p0[flush_nxt_idx] <= 2'd0;
      end else if (xfer) begin
        we_p1            <= 1'b1;
        idx_p1           <= xfer_idx;
        vbit_p1          <= new_cnt[1];
        cnt_p0[xfer_idx] <= new_cnt;
        if (sel_taken) begin
          tgt_we_p1 <= 1'b1;
          target_p1 <= sel_target;
        end
      end
    end
  end

  assign flush_busy = (state_p0 == FLUSH);
  assign btb_we     = we_p1;
  assign btb_idx    = idx_p1;
  assign btb_vbit   = vbit_p1;
  assign btb_tgt_we = tgt_we_p1;
  assign btb_target = target_p1;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a behavioural model predicts grants and
// BTB writes; a negedge monitor pops expected writes whenever btb_we is seen.
module tb_bp_update_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_taken = 1'b0, ex_ready;
  logic [31:0] ex_pc = 32'd0, ex_target = 32'd0;
  logic        jr_valid = 1'b0, jr_taken = 1'b0, jr_ready;
  logic [31:0] jr_pc = 32'd0, jr_target = 32'd0;
  logic        flush_req = 1'b0, flush_busy;
  logic        btb_we, btb_vbit, btb_tgt_we;
  logic [3:0]  btb_idx;
  logic [31:0] btb_target;

  bp_update_ctrl #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target), .ex_ready(ex_ready),
    .jr_valid(jr_valid), .jr_taken(jr_taken), .jr_pc(jr_pc), .jr_target(jr_target), .jr_ready(jr_ready),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .btb_we(btb_we), .btb_idx(btb_idx), .btb_vbit(btb_vbit),
    .btb_tgt_we(btb_tgt_we), .btb_target(btb_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          vbit;
    bit          tgt;
    logic [31:0] target;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // reference model state
  int  cnt_m [16];
  int  rr_m;
  int  flush_left;
  int  last_g;

  // pending requests, held until granted
  bit          ex_v, ex_t, jr_v, jr_t;
  logic [31:0] ex_p, ex_g, jr_p, jr_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    int  i;
    wr_t w;
    i = int'((pc >> 2) % 16);
    if (tk) cnt_m[i] = (cnt_m[i] == 3) ? 3 : cnt_m[i] + 1;
    else    cnt_m[i] = (cnt_m[i] == 0) ? 0 : cnt_m[i] - 1;
    w.idx = i; w.vbit = (cnt_m[i] >= 2); w.tgt = tk; w.target = tg;
    q.push_back(w);
  endtask

  // one clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic step(input bit fr);
    bit busy, blk, gex, gjr, fstart;
    wr_t w;
    ex_valid = ex_v; ex_taken = ex_t; ex_pc = ex_p; ex_target = ex_g;
    jr_valid = jr_v; jr_taken = jr_t; jr_pc = jr_p; jr_target = jr_g;
    flush_req = fr;
    #3;
    busy = (flush_left > 0);
    blk  = busy || fr;
    gex  = !blk && ex_v && (!jr_v || rr_m == 0);
    gjr  = !blk && jr_v && (!ex_v || rr_m == 1);
    chk("flush_busy", {31'd0, flush_busy}, {31'd0, busy});
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, gex});
    chk("jr_ready", {31'd0, jr_ready}, {31'd0, gjr});
    fstart = fr && !busy;
    last_g = -1;
    if (fstart) begin
      for (int i = 0; i < 16; i++) begin
        cnt_m[i] = 0;
        w.idx = i; w.vbit = 1'b0; w.tgt = 1'b0; w.target = 32'd0;
        q.push_back(w);
      end
    end else if (gex) begin
      model_update(ex_p, ex_t, ex_g); rr_m = 1; ex_v = 1'b0; last_g = 0;
    end else if (gjr) begin
      model_update(jr_p, jr_t, jr_g); rr_m = 0; jr_v = 1'b0; last_g = 1;
    end
    @(posedge clk); #1;
    if (fstart) flush_left = 16;
    else if (flush_left > 0) flush_left--;
  endtask

  task automatic do_reset();
    ex_valid = 1'b0; jr_valid = 1'b0; flush_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_btb_we", {31'd0, btb_we}, 32'd0);
    chk("rst_tgt_we", {31'd0, btb_tgt_we}, 32'd0);
    chk("rst_idx", {28'd0, btb_idx}, 32'd0);
    chk("rst_vbit", {31'd0, btb_vbit}, 32'd0);
    chk("rst_target", btb_target, 32'd0);
    chk("rst_busy", {31'd0, flush_busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    rr_m = 0; flush_left = 0; q.delete();
    ex_v = 1'b0; jr_v = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    ex_v = 1'b1; ex_p = pc; ex_t = tk; ex_g = tg;
  endtask

  task automatic set_jr(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    jr_v = 1'b1; jr_p = pc; jr_t = tk; jr_g = tg;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (btb_we) begin
        if (q.size() == 0) begin
          chk("unexpected_write_idx", {28'd0, btb_idx}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_idx", {28'd0, btb_idx}, e.idx);
          chk("wr_vbit", {31'd0, btb_vbit}, {31'd0, e.vbit});
          chk("wr_tgt_we", {31'd0, btb_tgt_we}, {31'd0, e.tgt});
          if (e.tgt) chk("wr_target", btb_target, e.target);
        end
      end else begin
        chk("idle_tgt_we", {31'd0, btb_tgt_we}, 32'd0);
      end
    end
  end

  initial begin
    bit granted;
    ex_v = 0; jr_v = 0; ex_t = 0; jr_t = 0;
    ex_p = 0; ex_g = 0; jr_p = 0; jr_g = 0;
    rr_m = 0; flush_left = 0; last_g = -1;
    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;

    // three taken updates to pc 0x40
    for (int i = 0; i < 3; i++) begin
      set_ex(32'h40, 1'b1, 32'h100);
      step(1'b0);
    end
    step(1'b0);

    // saturate pc 0x44 then walk it down with not-taken
    for (int i = 0; i < 3; i++) begin set_ex(32'h44, 1'b1, 32'h200); step(1'b0); end
    for (int i = 0; i < 3; i++) begin set_ex(32'h44, 1'b0, 32'h0); step(1'b0); end
    step(1'b0);

    // both requesters held after reset: round-robin ex, jr, ex, jr
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!ex_v) set_ex(32'h80 + 32'(i) * 4, 1'b1, 32'h300 + 32'(i));
      if (!jr_v) set_jr(32'h90 + 32'(i) * 4, 1'b0, 32'h0);
      step(1'b0);
      chk("rr_grant", last_g, i % 2);
    end
    ex_v = 1'b0; jr_v = 1'b0;
    step(1'b0);

    // pc 0x48 from counter 1: jr taken then ex not-taken
    set_ex(32'h48, 1'b1, 32'h480); step(1'b0);
    set_jr(32'h48, 1'b1, 32'h484); step(1'b0);
    set_ex(32'h48, 1'b0, 32'h0);   step(1'b0);
    step(1'b0);

    // flush with a pending ex that must wait out the walk
    set_ex(32'h4C, 1'b1, 32'h4C0);
    step(1'b1);
    granted = 1'b0;
    for (int i = 0; i < 20 && !granted; i++) begin
      step(1'b0);
      if (last_g == 0) begin
        granted = 1'b1;
        chk("flush_pending_wait", i, 16);
      end
    end
    if (!granted) chk("flush_pending_timeout", 32'd0, 32'd1);
    step(1'b0);

    // reset in the middle of a flush walk at idx 7
    step(1'b1);
    for (int i = 0; i < 7; i++) step(1'b0);
    chk("flush_idx_before_rst", {28'd0, btb_idx}, 32'd7);
    do_reset();
    set_ex(32'h5C, 1'b1, 32'h5C0); step(1'b0);
    step(1'b0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (!ex_v && ($urandom % 3 == 0))
        set_ex(($urandom & 32'hFFFF_0000) | ($urandom & 32'h3C), 1'($urandom % 2), $urandom);
      if (!jr_v && ($urandom % 3 == 0))
        set_jr(($urandom & 32'hFFFF_0000) | ($urandom & 32'h3C), 1'($urandom % 2), $urandom);
      step(($urandom % 60) == 0);
    end
    ex_v = 1'b0; jr_v = 1'b0;
    for (int c = 0; c < 20; c++) step(1'b0);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, BTB index width (16 entries); index = pc[IDX_W+1:2].
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ex_valid/ex_taken  input  1/1, ex_pc/ex_target  input  32/32; requester 0 is branch resolution.
REQ-005 SHALL have port ex_ready  output  1  requester 0 accept.
REQ-006 SHALL have ports jr_valid/jr_taken  input  1/1, jr_pc/jr_target  input  32/32; requester 1 is the jump unit.
REQ-007 SHALL have port jr_ready  output  1  requester 1 accept.
REQ-008 SHALL have port flush_req  input  1  single-cycle pulse requesting a BTB invalidate.
REQ-009 SHALL have port flush_busy  output  1  high while a flush walk is in progress.
REQ-010 SHALL have ports btb_we  output  1, btb_idx  output  IDX_W, btb_vbit  output  1; these form the prediction-bit write port.
REQ-011 SHALL have ports btb_tgt_we  output  1, btb_target  output  32; these form the target write port.

Function
REQ-012 SHALL keep an internal 2^IDX_W x 2-bit saturating counter table; prediction bit = counter[1].
REQ-013 SHALL implement FSM states IDLE and FLUSH; IDLE->FLUSH on flush_req; FLUSH->IDLE after index 2^IDX_W-1 is written.
REQ-014 SHALL handshake: a transfer occurs on a rising edge with valid&ready; valid/pc/taken/target must be held by the requester until that edge.
REQ-015 SHALL drive ready combinationally: both readies low in FLUSH or when flush_req=1.
REQ-016 SHALL, with one requester valid, ready only that requester; with both valid, ready only the one selected by the round-robin pointer.
REQ-017 SHALL, after each transfer, point round-robin at the other requester; the pointer is unchanged on idle cycles.
REQ-018 SHALL accept at most one transfer per cycle.
REQ-019 SHALL register the writes for a transfer at edge N and present them from N to N+1: btb_we=1, btb_idx=index, btb_vbit=new counter[1].
REQ-020 SHALL, for a taken transfer, increment the counter saturating at 3 and also pulse btb_tgt_we=1 with btb_target=target.
REQ-021 SHALL, for a not-taken transfer, decrement the counter saturating at 0; btb_tgt_we=0.
REQ-022 SHALL update the counter table at the transfer edge, so back-to-back transfers to the same index (either requester) see the prior update.
REQ-023 SHALL, in FLUSH, write one index per cycle starting at 0: btb_we=1, btb_vbit=0, btb_tgt_we=0, counter cleared to 0; the walk takes 2^IDX_W cycles.
REQ-024 SHALL assert flush_busy from the edge after flush_req through the final flush write cycle.
REQ-025 SHALL ignore flush_req while in FLUSH; a flush_req coinciding with valid blocks that transfer.
REQ-026 SHALL drive btb_we=0 and btb_tgt_we=0 in any cycle with no transfer or flush write.

Reset
REQ-027 SHALL, on rst=1, asynchronously set state=IDLE, every counter=0, round-robin pointer=requester 0, btb_we=0, btb_tgt_we=0, btb_idx=0, btb_vbit=0, btb_target=0, flush_busy=0.
REQ-028 SHALL, on reset during FLUSH, abandon the walk; the remaining entries are covered by the counter clear, and the external BTB is reinitialised by its own reset.

Verification
REQ-029 SHALL cover: ex taken pc=0x40 target=0x100 three times -> btb_idx=0 each; btb_vbit 0,1,1; btb_tgt_we=1, btb_target=0x100 each cycle after accept.
REQ-030 SHALL cover: counter at 3 for pc=0x44, ex not-taken twice -> btb_vbit 1 then 0, btb_tgt_we=0; a third not-taken stays at 0.
REQ-031 SHALL cover: ex_valid and jr_valid both held 4 cycles after reset -> grants ex, jr, ex, jr.
REQ-032 SHALL cover: flush_req pulse -> flush_busy high 16 cycles, btb_idx 0..15 with vbit=0, readies low throughout, pending ex accepted the cycle after flush_busy falls.
REQ-033 SHALL cover: rst asserted mid-flush at idx=7 -> all outputs at reset values immediately; the next taken update to any index gives btb_vbit=0 (counter=1).
REQ-034 SHALL cover: jr taken and ex not-taken to pc=0x48 on consecutive cycles from counter 1 -> btb_vbit 1 then 0.
